// File: rtl/nn_layer_sequencer_if.sv
// Control, address and enable bundle between the layer sequencer and its RAMs/datapath.
// master = sequencer side, slave = top-level control plus memories/accumulators.
interface nn_layer_sequencer_if #(
    parameter int unsigned AW = 10
);
    logic          start;
    logic [AW-1:0] num_inputs;
    logic [4:0]    num_neurons;
    logic [AW-1:0] weight_base;
    logic [AW-1:0] input_base;
    logic [AW-1:0] output_base;
    logic [15:0]   acc_q;
    logic [15:0]   sig_q;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] io_addr;
    logic          io_wren;
    logic [15:0]   io_data;
    logic [15:0]   sig_addr;
    logic [4:0]    acc_sel;
    logic          mac_clear;
    logic          mac_en;
    logic          bias_en;
    logic          busy;
    logic          done;

    modport master (
        input  start, num_inputs, num_neurons, weight_base, input_base, output_base,
        input  acc_q, sig_q,
        output w_addr, io_addr, io_wren, io_data, sig_addr, acc_sel,
        output mac_clear, mac_en, bias_en, busy, done
    );

    modport slave (
        output start, num_inputs, num_neurons, weight_base, input_base, output_base,
        output acc_q, sig_q,
        input  w_addr, io_addr, io_wren, io_data, sig_addr, acc_sel,
        input  mac_clear, mac_en, bias_en, busy, done
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Sequences one fully connected layer: MAC over N inputs, bias add, then sigmoid
// lookup and write-back of M neuron outputs through the shared IO RAM port.
module nn_layer_sequencer #(
    parameter int unsigned LANES  = 20,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned AW     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    nn_layer_sequencer_if.master bus
);

    localparam logic [AW-1:0]     AOne      = AW'(1);
    localparam logic [AW-1:0]     DrainLast = AW'(RD_LAT - 1);
    localparam logic [AW-1:0]     SdrLast   = AW'(RD_LAT);
    localparam logic [4:0]        MaxLanes  = 5'(LANES);
    localparam logic [RD_LAT-1:0] ShIn      = RD_LAT'(1);

    typedef enum logic [2:0] {
        StIdle, StMac, StBias, StDrain, StSig, StSdrain, StDone
    } state_e;

    state_e            state_q;
    logic [AW-1:0]     n_q, wb_q, ib_q, ob_q, cnt_q;
    logic [4:0]        m_q, wr_cnt_q;
    logic [RD_LAT-1:0] mac_sh_q, bias_sh_q, sig_sh_q;

    logic [AW-1:0]     w_addr_q, io_addr_q;
    logic              io_wren_q;
    logic [15:0]       io_data_q, sig_addr_q;
    logic [4:0]        acc_sel_q;
    logic              mac_clear_q, busy_q, done_q;

    logic [4:0]        m_clamped;
    logic [AW-1:0]     cnt_inc;

    always_comb begin
        m_clamped = (bus.num_neurons > MaxLanes) ? MaxLanes : bus.num_neurons;
        cnt_inc   = cnt_q + AOne;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            n_q         <= '0;
            wb_q        <= '0;
            ib_q        <= '0;
            ob_q        <= '0;
            cnt_q       <= '0;
            m_q         <= '0;
            wr_cnt_q    <= '0;
            mac_sh_q    <= '0;
            bias_sh_q   <= '0;
            sig_sh_q    <= '0;
            w_addr_q    <= '0;
            io_addr_q   <= '0;
            io_wren_q   <= 1'b0;
            io_data_q   <= '0;
            sig_addr_q  <= '0;
            acc_sel_q   <= '0;
            mac_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Issue bits ride a delay line matched to the RAM/ROM read latency.
            mac_sh_q  <= (mac_sh_q << 1) | ((state_q == StMac) ? ShIn : '0);
            bias_sh_q <= (bias_sh_q << 1) | ((state_q == StBias) ? ShIn : '0);
            sig_sh_q  <= (sig_sh_q << 1) | ((state_q == StSig) ? ShIn : '0);

            done_q      <= 1'b0;
            mac_clear_q <= 1'b0;

            if (state_q == StSig) begin
                sig_addr_q <= {~bus.acc_q[15], bus.acc_q[14:0]};
            end

            // Writes complete in issue order, so a running count gives the output slot.
            io_wren_q <= sig_sh_q[RD_LAT-1];
            if (sig_sh_q[RD_LAT-1]) begin
                io_addr_q <= ob_q + AW'(wr_cnt_q);
                io_data_q <= bus.sig_q;
                wr_cnt_q  <= wr_cnt_q + 5'd1;
            end

            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        n_q         <= bus.num_inputs;
                        m_q         <= m_clamped;
                        wb_q        <= bus.weight_base;
                        ib_q        <= bus.input_base;
                        ob_q        <= bus.output_base;
                        cnt_q       <= '0;
                        wr_cnt_q    <= '0;
                        busy_q      <= 1'b1;
                        mac_clear_q <= 1'b1;
                        w_addr_q    <= bus.weight_base;
                        if (bus.num_inputs == '0) begin
                            state_q <= StBias;
                        end else begin
                            state_q   <= StMac;
                            io_addr_q <= bus.input_base;
                        end
                    end
                end
                StMac: begin
                    if (cnt_q == n_q - AOne) begin
                        state_q  <= StBias;
                        w_addr_q <= wb_q + n_q;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q     <= cnt_inc;
                        w_addr_q  <= wb_q + cnt_inc;
                        io_addr_q <= ib_q + cnt_inc;
                    end
                end
                StBias: begin
                    state_q <= StDrain;
                    cnt_q   <= '0;
                end
                StDrain: begin
                    if (cnt_q == DrainLast) begin
                        cnt_q <= '0;
                        if (m_q == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= StSig;
                            acc_sel_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StSig: begin
                    if (acc_sel_q == m_q - 5'd1) begin
                        state_q <= StSdrain;
                        cnt_q   <= '0;
                    end else begin
                        acc_sel_q <= acc_sel_q + 5'd1;
                    end
                end
                StSdrain: begin
                    if (cnt_q == SdrLast) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.w_addr    = w_addr_q;
    assign bus.io_addr   = io_addr_q;
    assign bus.io_wren   = io_wren_q;
    assign bus.io_data   = io_data_q;
    assign bus.sig_addr  = sig_addr_q;
    assign bus.acc_sel   = acc_sel_q;
    assign bus.mac_clear = mac_clear_q;
    assign bus.mac_en    = mac_sh_q[RD_LAT-1];
    assign bus.bias_en   = bias_sh_q[RD_LAT-1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: stimulus pushes expected reads, writes and
// run lengths; a monitor pops and compares whenever the DUT presents an event.
module tb_nn_layer_sequencer;

    localparam int RD_LAT = 2;
    localparam int LANES  = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nn_layer_sequencer_if #(.AW(10)) bus ();

    nn_layer_sequencer #(.LANES(LANES), .RD_LAT(RD_LAT), .AW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] acc_vals [LANES];

    int exp_mw[$], exp_mi[$], exp_bw[$], exp_wa[$], exp_wd[$], exp_len[$];

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Injective ROM contents so a correct IO_Data also pins down the ROM address used.
    function automatic logic [15:0] rom_f(logic [15:0] a);
        return {a[6:0], a[15:7]} ^ 16'hC3A5;
    endfunction

    always_comb bus.acc_q = (bus.acc_sel < 5'(LANES)) ? acc_vals[bus.acc_sel] : 16'h0;

    // Address registered on one edge, Q valid for sampling RD_LAT-1 cycles later.
    always @(posedge clk) bus.sig_q <= rom_f(bus.sig_addr);

    function automatic void push_expect(int n, int m, int wb, int ib, int ob);
        int mc;
        mc = (m > LANES) ? LANES : m;
        for (int k = 0; k < n; k++) begin
            exp_mw.push_back((wb + k) % 1024);
            exp_mi.push_back((ib + k) % 1024);
        end
        exp_bw.push_back((wb + n) % 1024);
        for (int i = 0; i < mc; i++) begin
            exp_wa.push_back((ob + i) % 1024);
            exp_wd.push_back(int'(rom_f(acc_vals[i] ^ 16'h8000)));
        end
        exp_len.push_back(n + 1 + RD_LAT + mc + ((mc > 0) ? 1 + RD_LAT : 0) + 1);
    endfunction

    function automatic void clear_expect();
        exp_mw.delete(); exp_mi.delete(); exp_bw.delete();
        exp_wa.delete(); exp_wd.delete(); exp_len.delete();
    endfunction

    // Monitor
    int busy_cnt = 0;
    int w_hist[RD_LAT+1];
    int i_hist[RD_LAT+1];

    initial begin : monitor
        forever begin
            @(negedge clk);
            for (int i = RD_LAT; i > 0; i--) begin
                w_hist[i] = w_hist[i-1];
                i_hist[i] = i_hist[i-1];
            end
            w_hist[0] = int'(bus.w_addr);
            i_hist[0] = int'(bus.io_addr);
            if (bus.busy) busy_cnt++;
            else busy_cnt = 0;

            if (bus.mac_clear) check("mac_clear_cycle", busy_cnt, 1);
            if (bus.mac_en) begin
                check("mac_en_expected", int'(exp_mw.size() > 0), 1);
                if (exp_mw.size() > 0) begin
                    check("mac_w_addr", w_hist[RD_LAT], exp_mw.pop_front());
                    check("mac_io_addr", i_hist[RD_LAT], exp_mi.pop_front());
                end
            end
            if (bus.bias_en) begin
                check("bias_mac_overlap", int'(bus.mac_en), 0);
                check("bias_en_expected", int'(exp_bw.size() > 0), 1);
                if (exp_bw.size() > 0) check("bias_w_addr", w_hist[RD_LAT], exp_bw.pop_front());
            end
            if (bus.io_wren) begin
                check("wren_during_read", int'(bus.mac_en | bus.bias_en), 0);
                check("wren_expected", int'(exp_wa.size() > 0), 1);
                if (exp_wa.size() > 0) begin
                    check("wr_addr", int'(bus.io_addr), exp_wa.pop_front());
                    check("wr_data", int'(bus.io_data), exp_wd.pop_front());
                end
            end
            if (bus.done) begin
                check("done_expected", int'(exp_len.size() > 0), 1);
                if (exp_len.size() > 0) check("busy_length", busy_cnt, exp_len.pop_front());
                check("mac_left", exp_mw.size(), 0);
                check("bias_left", exp_bw.size(), 0);
                check("wr_left", exp_wa.size(), 0);
            end
        end
    end

    // Stimulus
    task automatic randomize_acc();
        for (int i = 0; i < LANES; i++) acc_vals[i] = 16'($urandom);
    endtask

    task automatic scramble_inputs();
        bus.num_inputs  = 10'($urandom);
        bus.num_neurons = 5'($urandom);
        bus.weight_base = 10'($urandom);
        bus.input_base  = 10'($urandom);
        bus.output_base = 10'($urandom);
    endtask

    task automatic launch(int n, int m, int wb, int ib, int ob);
        push_expect(n, m, wb, ib, ob);
        @(negedge clk);
        #1;
        bus.num_inputs  = 10'(n);
        bus.num_neurons = 5'(m);
        bus.weight_base = 10'(wb);
        bus.input_base  = 10'(ib);
        bus.output_base = 10'(ob);
        bus.start       = 1'b1;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_idle(bit poke);
        int cyc = 0;
        while (bus.busy && cyc < 4000) begin
            @(negedge clk);
            #1;
            cyc++;
            bus.start = poke && (cyc % 7 == 3);
        end
        bus.start = 1'b0;
        if (cyc >= 4000) check("run_timeout", 1, 0);
    endtask

    task automatic run(int n, int m, int wb, int ib, int ob, bit poke);
        launch(n, m, wb, ib, ob);
        wait_idle(poke);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset(string tag);
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_outputs"}, $countones({bus.w_addr, bus.io_addr, bus.io_wren, bus.io_data,
              bus.sig_addr, bus.acc_sel, bus.mac_clear, bus.mac_en, bus.bias_en, bus.done}), 0);
        clear_expect();
        #1;
        reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin : stim
        int cyc;
        reset     = 1'b1;
        bus.start = 1'b0;
        scramble_inputs();
        randomize_acc();
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_outputs", $countones({bus.w_addr, bus.io_addr, bus.io_wren, bus.io_data,
              bus.sig_addr, bus.acc_sel, bus.mac_clear, bus.mac_en, bus.bias_en, bus.done}), 0);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full MNIST hidden layer
        run(784, 20, 0, 0, 0, 1'b0);
        // No inputs: clear and bias in the first busy cycle
        randomize_acc();
        run(0, 3, 17, 5, 600, 1'b0);
        // No neurons, then over-range neuron count
        run(9, 0, 100, 200, 300, 1'b1);
        randomize_acc();
        run(4, 25, 3, 1000, 1010, 1'b0);
        // Weight address wrap
        run(6, 2, 1020, 1021, 50, 1'b0);
        // Offset-binary sigmoid addressing at the extremes
        acc_vals[0] = 16'h8000;
        acc_vals[1] = 16'h0000;
        acc_vals[2] = 16'h7FFF;
        run(2, 3, 0, 0, 40, 1'b0);

        // Reset mid-MAC and mid-SIG
        randomize_acc();
        launch(30, 5, 10, 20, 30);
        repeat (5) @(negedge clk);
        pulse_reset("rst_mac");
        launch(10, 20, 0, 0, 64);
        repeat (18) @(negedge clk);
        pulse_reset("rst_sig");

        // Start held across the DONE edge is ignored, then taken on the first IDLE edge
        launch(3, 2, 7, 8, 9);
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", int'(bus.done), 1);
        #1;
        randomize_acc();
        push_expect(5, 4, 900, 901, 902);
        bus.num_inputs  = 10'd5;
        bus.num_neurons = 5'd4;
        bus.weight_base = 10'd900;
        bus.input_base  = 10'd901;
        bus.output_base = 10'd902;
        bus.start       = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", int'(bus.busy), 0);
        @(negedge clk);
        check("start_after_done_taken", int'(bus.busy), 1);
        #1;
        bus.start = 1'b0;
        scramble_inputs();
        wait_idle(1'b1);
        repeat (2) @(negedge clk);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            randomize_acc();
            run($urandom_range(0, 40), $urandom_range(0, 25), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
        end

        repeat (10) @(negedge clk);
        check("runs_pending", exp_len.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
Sequences one fully connected layer of the MNIST network. It drives a broadcast address to the 20 parallel weight/bias RAMs, the input/output RAM address and write strobe, and the sigmoid ROM address. It also issues MAC/bias enables to the 20-lane accumulator datapath. It sits between the top-level control FSM (Start/Done) and the ram_weights_biases / ram_input_output / sdram_sigmoid instances. It time-shares the single IO RAM port: reads during accumulation, writes during activation.

Parameters:
LANES, 20, number of parallel neurons / weight RAMs
RD_LAT, 2, cycles from address driven to RAM/ROM Q valid for sampling (must be >= 1)
AW, 10, weight and IO RAM address width

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Start  in  1  one-cycle request to run a layer; ignored while Busy
NumInputs  in  10  inputs per neuron N (0..1023)
NumNeurons  in  5  active lanes M; 0 means no writes; values >LANES are clamped to LANES
WeightBase  in  10  first weight address in every lane RAM
InputBase  in  10  first input address in IO RAM
OutputBase  in  10  first output address in IO RAM
Acc_Q  in  16  signed saturated accumulator of the lane selected by Acc_Sel (combinational from datapath)
Sig_Q  in  16  sigmoid ROM output
W_Addr  out  10  broadcast address to all lane RAMs
IO_Addr  out  10  IO RAM address
IO_Wren  out  1  IO RAM write enable
IO_Data  out  16  IO RAM write data
Sig_Addr  out  16  sigmoid ROM address
Acc_Sel  out  5  lane select for Acc_Q mux
MAC_Clear  out  1  clear all lane accumulators
MAC_En  out  1  accumulate W_Q*IO_Q in every lane this cycle
Bias_En  out  1  add W_Q (bias) in every lane this cycle
Busy  out  1  high in every non-IDLE state
Done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered. Reset forces all of them to 0 and the FSM to IDLE in the same edge, from any state. Pending delayed enables and writes are flushed; no IO_Wren appears after Reset.
- Start, the base addresses, NumInputs and NumNeurons are sampled in IDLE when Start=1. Later input changes have no effect until the next run.
- Address arithmetic is modulo 2^AW (wraps; no error).
- States and transitions:
  - IDLE: on Start, go to MAC, or to BIAS when N=0.
  - MAC: counter k=0..N-1, one per cycle.
    - W_Addr=WeightBase+k, IO_Addr=InputBase+k.
    - MAC_Clear=1 only in the k=0 cycle, or in the BIAS cycle when N=0.
    - An issue bit enters an RD_LAT-deep delay line; MAC_En is its output.
    - After k=N-1, go to BIAS.
  - BIAS: 1 cycle. W_Addr=WeightBase+N. Bias_En is asserted RD_LAT cycles later. Go to DRAIN.
  - DRAIN: RD_LAT cycles, so the last Bias_En has been issued before the next state. Then go to SIG, or to DONE when M=0.
  - SIG: counter n=0..M-1, one per cycle.
    - Acc_Sel=n.
    - One cycle later, Sig_Addr = Acc_Q with bit 15 inverted (offset binary: 0x0000 maps to -32768).
    - RD_LAT cycles after Sig_Addr: IO_Wren=1, IO_Addr=OutputBase+n, IO_Data=Sig_Q.
    - After n=M-1, go to SDRAIN.
  - SDRAIN: 1+RD_LAT cycles, until the last write completes. Go to DONE.
  - DONE: Done=1 for 1 cycle, Busy still 1. Go to IDLE.
- Busy length = N+1+RD_LAT+M+(M>0 ? 1+RD_LAT : 0)+1 cycles.
- MAC_En and Bias_En never overlap. IO_Wren never occurs while MAC/BIAS reads are in flight.
- In DRAIN/SDRAIN/DONE/IDLE, W_Addr and IO_Addr hold their last value. IO_Wren=0 except during the write pipeline.
- Start asserted in the DONE cycle is ignored. Start in the first IDLE cycle after DONE is accepted.

Test Plan:
- Reset, then N=784, M=20, all bases 0, RD_LAT=2 -> MAC_En high 784 cycles and first seen 2 cycles after k=0. Bias_En once with W_Addr=784. 20 writes to IO 0..19. Done 811 cycles after Start.
- N=0, M=3 -> no MAC_En. MAC_Clear and BIAS in the first Busy cycle, Bias_En once. Writes to OutputBase..+2. Done pulse once.
- M=0 and M=25 -> M=0: zero IO_Wren, Done after N+RD_LAT+2 Busy cycles. M=25: exactly 20 writes (clamped).
- WeightBase=1020, N=6 -> W_Addr sequence 1020,1021,1022,1023,0,1,2 (last is bias); no stall.
- Acc_Q values 0x8000, 0x0000, 0x7FFF on lanes 0..2 with ROM model -> Sig_Addr 0x0000, 0x8000, 0xFFFF. IO_Data equals the model Q at the matching IO_Addr.
- Reset pulsed mid-MAC and again mid-SIG -> next cycle Busy=0, all outputs 0, no further IO_Wren. Start pulses during Busy produce no second run.
